// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC, instruction-memory read issue and prefetch FIFO feeding decode
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0020,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_hold,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int                 PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]     C_DEPTH = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]   C_LAST  = PTR_W'(DEPTH - 1);

    logic [31:0]      r_fpc;
    logic [31:0]      r_pend_pc;
    logic             r_pending;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [15:0]      r_instr_q [DEPTH];
    logic [31:0]      r_pc_q    [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [CNT_W:0]   w_credit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign if_valid = (r_count != '0);
    assign w_pop    = if_valid & id_ready;
    assign w_push   = r_pending;

    // Occupancy the FIFO would have if every outstanding read lands, crediting this cycle's pop.
    assign w_credit = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pending} - {{CNT_W{1'b0}}, w_pop};
    assign w_issue  = reset & ~fetch_hold & ~redirect & (w_credit < C_DEPTH);

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_fpc;
    assign if_instr   = r_instr_q[r_rd_ptr];
    assign if_pc      = r_pc_q[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fpc     <= RESET_PC;
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
        end else if (redirect) begin
            r_fpc     <= redirect_pc;
            r_pending <= 1'b0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_fpc     <= r_fpc + 32'd1;
                r_pend_pc <= r_fpc;
            end
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (reset && !redirect && w_push) begin
            r_instr_q[r_wr_ptr] <= imem_rdata;
            r_pc_q[r_wr_ptr]    <= r_pend_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : directed self-checking bench for fetch_stage
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        fetch_hold;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_pc;
    logic        overflow_seen;

    fetch_stage #(
        .RESET_PC (32'h0000_0020),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_hold  (fetch_hold),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [31:0] a);
        case (a)
            32'h20:  return 16'h89BF;
            32'h21:  return 16'h44BF;
            32'h22:  return 16'h68BF;
            32'h40:  return 16'hA123;
            default: return a[15:0] ^ 16'hB5B5;
        endcase
    endfunction

    // Synchronous instruction memory: data appears the cycle after the request.
    initial imem_rdata = 16'h0;
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= memf(imem_addr);
    end

    initial overflow_seen = 1'b0;
    always @(posedge clk) begin
        if (reset && !redirect && dut.r_pending && (int'(dut.r_count) == DEPTH)
            && !(if_valid && id_ready))
            overflow_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, then check the delivered head against the expected PC stream.
    task automatic drive(input logic rst_n, input logic rdy, input logic hold,
                         input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset       = rst_n;
        id_ready    = rdy;
        fetch_hold  = hold;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        if (!rst_n || hold) check_val("rd_en_blocked", {31'b0, imem_rd_en}, 32'd0);
        if (rst_n && if_valid) begin
            check_val("head_pc", if_pc, exp_pc);
            check_val("head_instr", {16'b0, if_instr}, {16'b0, memf(exp_pc)});
        end
        if (!rst_n)                exp_pc = 32'h20;
        else if (redir)            exp_pc = rpc;
        else if (if_valid && rdy)  exp_pc = exp_pc + 32'd1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_pc = 32'h20;
        reset = 1'b0; fetch_hold = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;

        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check_val("rst_valid", {31'b0, if_valid}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h20);

        drive(1, 1, 0, 0, 0);                                   // cycle 0
        check_val("c0_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check_val("c0_addr", imem_addr, 32'h20);
        check_val("c0_valid", {31'b0, if_valid}, 32'd0);
        drive(1, 1, 0, 0, 0);                                   // cycle 1
        check_val("c1_valid", {31'b0, if_valid}, 32'd0);
        check_val("c1_addr", imem_addr, 32'h21);
        drive(1, 1, 0, 0, 0);                                   // cycle 2
        check_val("c2_valid", {31'b0, if_valid}, 32'd1);
        check_val("c2_instr", {16'b0, if_instr}, 32'h89BF);
        check_val("c2_pc", if_pc, 32'h20);

        for (int c = 3; c <= 8; c++) begin                      // stall
            drive(1, 0, 0, 0, 0);
            check_val("stall_instr", {16'b0, if_instr}, 32'h44BF);
            check_val("stall_pc", if_pc, 32'h21);
            if (c >= 4) check_val("stall_full_rd_en", {31'b0, imem_rd_en}, 32'd0);
        end
        check_val("stall_count", {30'b0, dut.r_count}, DEPTH);

        for (int c = 9; c <= 13; c++) drive(1, 1, 0, 0, 0);
        for (int c = 14; c <= 17; c++) drive(1, 1, 1, 0, 0);    // fetch hold
        drive(1, 1, 0, 0, 0);                                   // cycle 18
        check_val("hold_resume_addr", imem_addr, 32'h28);
        check_val("hold_resume_rd_en", {31'b0, imem_rd_en}, 32'd1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);                                   // cycle 20
        check_val("hold_resume_pc", if_pc, 32'h28);
        drive(1, 1, 0, 0, 0);

        drive(1, 1, 0, 1, 32'h40);                              // redirect, cycle 22
        check_val("redir_rd_en", {31'b0, imem_rd_en}, 32'd0);
        drive(1, 1, 0, 0, 0);
        check_val("redir_r1_valid", {31'b0, if_valid}, 32'd0);
        check_val("redir_r1_addr", imem_addr, 32'h40);
        check_val("redir_r1_rd_en", {31'b0, imem_rd_en}, 32'd1);
        drive(1, 1, 0, 0, 0);
        check_val("redir_r2_valid", {31'b0, if_valid}, 32'd0);
        drive(1, 1, 0, 0, 0);                                   // cycle 25
        check_val("redir_r3_valid", {31'b0, if_valid}, 32'd1);
        check_val("redir_r3_instr", {16'b0, if_instr}, 32'hA123);
        check_val("redir_r3_pc", if_pc, 32'h40);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        drive(0, 1, 0, 0, 0);                                   // reset mid-stream, cycle 28
        drive(1, 1, 0, 0, 0);
        check_val("mrst_valid", {31'b0, if_valid}, 32'd0);
        check_val("mrst_addr", imem_addr, 32'h20);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);                                   // cycle 31
        check_val("mrst_instr", {16'b0, if_instr}, 32'h89BF);
        check_val("mrst_pc", if_pc, 32'h20);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        drive(1, 1, 0, 1, 32'hFFFF_FFFF);                       // wrap, cycle 34
        drive(1, 1, 0, 0, 0);
        check_val("wrap_addr", imem_addr, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);                                   // cycle 37
        check_val("wrap_pc_hi", if_pc, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 0);
        check_val("wrap_pc_zero", if_pc, 32'h0000_0000);
        check_val("wrap_instr_zero", {16'b0, if_instr}, 32'hB5B5);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        check_val("no_overflow", {31'b0, overflow_seen}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 16-bit pipelined processor; sits directly upstream of the decode/ALU stages. Keeps the program counter, issues reads to the synchronous instruction memory, and buffers returned 16-bit instruction words in a small prefetch FIFO that feeds decode through a valid/ready handshake. Supports stall from decode, PC redirect (branch/jump) with flush, and a fetch hold while the instruction memory is being loaded.

## Interface
- `RESET_PC`, 32'h0000_0020: PC value after reset; the program image is loaded from this address.
- `DEPTH`, 2: prefetch FIFO entries; legal values are 2 to 8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset. Sampled on the `clk` rising edge; 0 resets the block.
- `fetch_hold` in 1: 1 means no new memory reads are issued, e.g. while the instruction memory write port is active. Buffered words still drain.
- `imem_rd_en` out 1: read request to instruction memory.
- `imem_addr` out 32: read word address; always equals the fetch PC register.
- `imem_rdata` in 16: read data, valid in the cycle after the request.
- `redirect` in 1: a taken branch or jump; 1-cycle pulse.
- `redirect_pc` in 32: target address, valid while `redirect`=1.
- `if_valid` out 1: the FIFO head holds a valid instruction.
- `if_instr` out 16: the instruction at the FIFO head.
- `if_pc` out 32: the address of `if_instr`.
- `id_ready` in 1: decode accepts the head this cycle. A pop happens when `if_valid` & `id_ready`.

## Operation
- State:
  - fetch PC `fpc` (32 bits).
  - `pending` flag: one read is in flight.
  - `pend_pc`: the address of the in-flight read.
  - FIFO of {instr, pc} entries with `count` from 0 to DEPTH.
- Issue rule: `imem_rd_en` = `reset` & !`fetch_hold` & !`redirect` & (`count` + `pending` − pop < DEPTH).
  - On issue, `fpc` <= `fpc`+1 (word addressing). `fpc` wraps modulo 2^32 with no flag.
  - On issue, `pending` <= 1 and `pend_pc` <= `fpc`. Otherwise `pending` <= 0.
- Response: when `pending`=1, `imem_rdata` and `pend_pc` are pushed into the FIFO at the next edge.
  - The issue rule guarantees space, so an overflow push is impossible. Verification asserts this.
- Pop: the head is removed at the edge where `if_valid` & `id_ready`. Push and pop in the same cycle leave `count` unchanged.
- FIFO order is strict: `if_pc` values increase by 1 between pops unless a redirect occurred.
- Redirect (priority over issue, push and pop):
  - `fpc` <= `redirect_pc`.
  - FIFO emptied (`count` <= 0).
  - `pending` <= 0, so the in-flight response returning next cycle is discarded.
  - No read is issued in the redirect cycle.
- Reset (highest priority):
  - `fpc` <= RESET_PC, `count` <= 0, `pending` <= 0.
  - A read in flight when reset is asserted mid-operation is discarded.
- `fetch_hold`: blocks only issue. A read already pending still completes and is pushed.
- Stall (`id_ready`=0):
  - The head and `if_valid` hold steady; `if_instr` and `if_pc` must not change while `if_valid`=1 and no pop occurs.
  - Fetch continues until the FIFO is full, then `imem_rd_en` drops.

## Timing
- Reset values:
  - `if_valid`=0, `imem_rd_en`=0 (forced while `reset`=0).
  - `imem_addr`=RESET_PC.
  - `if_instr` and `if_pc` hold the last values (don't-care while `if_valid`=0).
- Read issued in cycle N: `imem_rdata` is valid in N+1, the word is pushed at the end of N+1, and `if_valid`=1 in N+2. No bypass.
- First instruction: `reset` released for cycle 0 gives issue in cycle 0 and `if_valid` in cycle 2.
- Sustained throughput is 1 instruction/cycle with `id_ready`=1 and DEPTH ≥ 2.
- Redirect in cycle R:
  - `if_valid`=0 in R+1.
  - Issue at `redirect_pc` in R+1.
  - First target instruction valid in R+3.
- Full FIFO with pop in the same cycle: issue is allowed (credit counts the pop).

## Test plan
- Reset and stream:
  - Stimulus: memory holds 0x89BF @0x20, 0x44BF @0x21, 0x68BF @0x22; release `reset`; `id_ready`=1.
  - Response: `if_valid` rises in cycle 2; `if_instr`/`if_pc` = 0x89BF/0x20, 0x44BF/0x21, 0x68BF/0x22 on consecutive cycles.
- Stall:
  - Stimulus: `id_ready`=0 from cycle 3 to cycle 8.
  - Response: the head stays 0x44BF/0x21; `count` reaches DEPTH; `imem_rd_en`=0 while full; no word is lost or duplicated after `id_ready`=1 resumes.
- Redirect:
  - Stimulus: pulse `redirect` with `redirect_pc`=0x40 (memory 0x40=0xA123) while a read is pending and the FIFO is non-empty.
  - Response: `if_valid`=0 next cycle; the next delivered word is 0xA123/0x40; no stale word from 0x2x appears.
- Fetch hold:
  - Stimulus: `fetch_hold`=1 for 4 cycles mid-stream.
  - Response: `imem_rd_en`=0 throughout; the pending word is still delivered; the stream resumes at the correct next PC with no gap in `if_pc`.
- Reset mid-operation:
  - Stimulus: `reset`=0 for 1 cycle with a pending read and a full FIFO.
  - Response: `if_valid`=0 and `imem_addr`=0x20 the next cycle; fetch restarts at 0x20 with 0x89BF.
- Wrap:
  - Stimulus: redirect to 0xFFFF_FFFF.
  - Response: `if_pc` sequence 0xFFFF_FFFF then 0x0000_0000.
